// File: rtl/led_pattern_gen.sv
// LED pattern generator: a programmable prescaler produces a step tick, and
// on each tick the LED register advances in COUNT, ROTATE, BOUNCE or FREEZE mode.
module led_pattern_gen #(
    parameter int unsigned           LED_W         = 8,
    parameter int unsigned           PRE_W         = 24,
    parameter logic [LED_W-1:0]      RESET_PATTERN = LED_W'(8'hAA)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [3:0]       speed,
    output logic [LED_W-1:0] led,
    output logic             tick,
    output logic             wrap
);

    typedef enum logic [1:0] {
        M_COUNT  = 2'd0,
        M_ROTATE = 2'd1,
        M_BOUNCE = 2'd2,
        M_FREEZE = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [LED_W-1:0] LED_ONE = {{(LED_W-1){1'b0}}, 1'b1};
    localparam logic [PRE_W-1:0] PRE_MAX = '1;
    localparam logic [31:0]      SPD_MAX = 32'(PRE_W - 1);

    logic [LED_W-1:0] led_q, led_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    dir_e             dir_q, dir_d;
    mode_e            mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;

    mode_e            mode_in;
    logic [31:0]      shamt;
    logic [PRE_W-1:0] term;
    logic             step;

    assign mode_in = mode_e'(mode);

    // Terminal count: full-scale prescaler shifted down by the clamped speed.
    always_comb begin
        shamt = ({28'd0, speed} > SPD_MAX) ? SPD_MAX : {28'd0, speed};
        term  = PRE_MAX >> shamt;
    end

    // Next-state logic: mode-change seeding, prescaler, and per-mode step rules.
    always_comb begin
        led_d  = led_q;
        pre_d  = pre_q;
        dir_d  = dir_q;
        mode_d = mode_in;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        step   = 1'b0;

        if (mode_in != mode_q) begin
            // A new mode restarts the prescaler and loads its seed instead of stepping.
            pre_d = '0;
            case (mode_in)
                M_COUNT:  led_d = '0;
                M_ROTATE: led_d = LED_ONE;
                M_BOUNCE: begin
                    led_d = LED_ONE;
                    dir_d = DIR_LEFT;
                end
                default:  led_d = led_q;
            endcase
        end else if (en) begin
            // >= so that lowering the terminal count mid-count steps at once.
            if (pre_q >= term) begin
                pre_d = '0;
                step  = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end

        if (step) begin
            tick_d = 1'b1;
            case (mode_q)
                M_COUNT: begin
                    led_d  = led_q + 1'b1;
                    wrap_d = &led_q;
                end
                M_ROTATE: begin
                    if (led_q == '0) begin
                        led_d = LED_ONE;
                    end else begin
                        led_d  = {led_q[LED_W-2:0], led_q[LED_W-1]};
                        wrap_d = led_q[LED_W-1];
                    end
                end
                M_BOUNCE: begin
                    if (!$onehot(led_q)) begin
                        led_d = LED_ONE;
                        dir_d = DIR_LEFT;
                    end else if (dir_q == DIR_LEFT) begin
                        led_d = led_q << 1;
                        if (led_d[LED_W-1]) dir_d = DIR_RIGHT;
                    end else begin
                        led_d = led_q >> 1;
                        if (led_d[0]) begin
                            dir_d  = DIR_LEFT;
                            wrap_d = 1'b1;
                        end
                    end
                end
                default: led_d = led_q;
            endcase
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q  <= RESET_PATTERN;
            pre_q  <= '0;
            dir_q  <= DIR_LEFT;
            mode_q <= M_COUNT;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            pre_q  <= pre_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign led  = led_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: expected steps are queued as stimulus
// is applied and checked against each tick the DUT produces.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] speed;
    logic [7:0] led;
    logic       tick;
    logic       wrap;

    typedef struct {
        logic [7:0]  led;
        logic        wrap;
        int unsigned gap;
    } exp_t;

    exp_t        sb[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    int unsigned last  = 0;

    led_pattern_gen #(
        .LED_W        (8),
        .PRE_W        (4),
        .RESET_PATTERN(8'hAA)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .speed(speed),
        .led  (led),
        .tick (tick),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used to measure tick spacing.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] l, input logic w, input int unsigned g);
        exp_t e;
        e.led  = l;
        e.wrap = w;
        e.gap  = g;
        sb.push_back(e);
    endtask

    // Wait (bounded) for the next tick and compare it with the oldest expectation.
    task automatic wait_tick();
        exp_t        e;
        int unsigned n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 100);
        e = sb.pop_front();
        chk("tick_seen", {31'd0, tick}, 32'd1);
        chk("step_led", {24'd0, led}, {24'd0, e.led});
        chk("step_wrap", {31'd0, wrap}, {31'd0, e.wrap});
        chk("step_gap", cyc - last, e.gap);
        last = cyc;
    endtask

    task automatic drain();
        while (sb.size() > 0) wait_tick();
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        mode  = 2'd0;
        speed = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_led", {24'd0, led}, 32'hAA);
        chk("reset_tick", {31'd0, tick}, 32'd0);
        chk("reset_wrap", {31'd0, wrap}, 32'd0);

        // COUNT at the slowest rate: 16 cycles per step, counting from the reset pattern.
        rst  = 1'b0;
        last = cyc;
        push(8'hAB, 1'b0, 16);
        push(8'hAC, 1'b0, 16);
        drain();

        // COUNT fast (T=1) up to all-ones, then wrap to zero.
        speed = 4'd3;
        for (int v = 'hAD; v <= 'hFF; v++) push(8'(v), 1'b0, 2);
        push(8'h00, 1'b1, 2);
        drain();
        @(negedge clk);
        chk("wrap_one_cycle", {31'd0, wrap}, 32'd0);
        chk("tick_one_cycle", {31'd0, tick}, 32'd0);

        // ROTATE: seed 01, walk to 80, wrap back to 01.
        mode = 2'd1;
        @(negedge clk);
        chk("rotate_seed", {24'd0, led}, 32'h01);
        chk("rotate_seed_tick", {31'd0, tick}, 32'd0);
        last = cyc;
        for (int b = 1; b < 8; b++) push(8'(1 << b), 1'b0, 2);
        push(8'h01, 1'b1, 2);
        drain();

        // BOUNCE: 14-step period, wrap only on arrival back at 01.
        mode = 2'd2;
        @(negedge clk);
        chk("bounce_seed", {24'd0, led}, 32'h01);
        last = cyc;
        for (int b = 1; b < 8; b++) push(8'(1 << b), 1'b0, 2);
        for (int b = 6; b > 0; b--) push(8'(1 << b), 1'b0, 2);
        push(8'h01, 1'b1, 2);
        push(8'h02, 1'b0, 2);
        drain();

        // Raise speed with the prescaler at 12: step on the very next cycle.
        speed = 4'd0;
        repeat (12) @(negedge clk);
        speed = 4'd3;
        push(8'h04, 1'b0, 13);
        drain();

        // en=0 for 20 cycles with the prescaler at 5: everything holds.
        speed = 4'd0;
        repeat (5) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_tick", {31'd0, tick}, 32'd0);
            chk("hold_led", {24'd0, led}, 32'h04);
        end
        en = 1'b1;
        push(8'h08, 1'b0, 36);
        drain();

        // Asynchronous reset between edges while BOUNCE shows 10.
        speed = 4'd3;
        push(8'h10, 1'b0, 2);
        drain();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_led", {24'd0, led}, 32'hAA);
        chk("async_rst_tick", {31'd0, tick}, 32'd0);
        chk("async_rst_wrap", {31'd0, wrap}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_seed", {24'd0, led}, 32'h01);
        chk("post_rst_tick", {31'd0, tick}, 32'd0);
        last = cyc;
        push(8'h02, 1'b0, 2);
        drain();

        // FREEZE keeps the pattern but still ticks.
        mode = 2'd3;
        @(negedge clk);
        chk("freeze_seed", {24'd0, led}, 32'h02);
        last = cyc;
        push(8'h02, 1'b0, 2);
        push(8'h02, 1'b0, 2);
        drain();

        // Back to COUNT: seed is zero.
        mode = 2'd0;
        @(negedge clk);
        chk("count_seed", {24'd0, led}, 32'h00);
        last = cyc;
        push(8'h01, 1'b0, 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern generator. It is the successor to the single-mode free-running LED counter. A programmable prescaler produces a step tick. On each tick the LED register advances according to one of four selectable modes: binary count, rotate, bounce or freeze. The block drives the board LED bank directly and gives status pulses to the surrounding lab top-level.

Parameters:
LED_W, 8, number of LED outputs; minimum 2.
PRE_W, 24, prescaler counter width; sets the slowest step rate.
RESET_PATTERN, 8'hAA (LED_W bits), LED value loaded on reset.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
en  input  1  1 = prescaler and pattern advance; 0 = hold
mode  input  2  0 COUNT, 1 ROTATE, 2 BOUNCE, 3 FREEZE
speed  input  4  rate select; a larger value gives faster steps
led  output  LED_W  registered LED pattern
tick  output  1  one-cycle pulse on every pattern step
wrap  output  1  one-cycle pulse when the pattern completes a cycle

Behaviour:
- Reset (async, rst=1): led=RESET_PATTERN, prescaler=0, dir=LEFT, mode_q=0, tick=0, wrap=0.
- Effective speed: s = min(speed, PRE_W-1). Terminal count T = (2^PRE_W - 1) >> s.
- Prescaler, when en=1 and no mode change:
  - if prescaler >= T: prescaler<=0 and a step occurs this cycle (tick=1 next cycle, together with the new led).
  - else prescaler increments.
  - Using >= means lowering T mid-count (raising speed) forces a step on the next cycle, never a 2^PRE_W stall.
- Period between ticks is T+1 cycles. All outputs are registered, so led, tick and wrap change on the same edge.
- en=0: prescaler, led and dir hold; tick=0 and wrap=0. Mode-change handling (below) still applies.
- Mode change: mode_q registers mode every cycle. If mode != mode_q, in that cycle:
  - prescaler<=0, no step, tick=0.
  - led loads the seed: COUNT 0, ROTATE 1, BOUNCE 1 with dir=LEFT, FREEZE holds the current led.
- Step rules (mode_q == mode):
  - COUNT: led <= led+1, modulo 2^LED_W. wrap=1 when led goes from all-ones to 0. Counting starts from the current led, so after reset with mode=0 the first step gives RESET_PATTERN+1.
  - ROTATE: led <= {led[LED_W-2:0], led[LED_W-1]}. If led==0, load 1 instead. wrap=1 when bit LED_W-1 moves to bit 0.
  - BOUNCE: one-hot walk.
    - dir LEFT: shift left. On reaching bit LED_W-1, set dir=RIGHT.
    - dir RIGHT: shift right. On reaching bit 0, set dir=LEFT and wrap=1.
    - If led is not one-hot at a step, load 1, dir=LEFT, no wrap.
  - FREEZE: led holds. Prescaler still runs and tick still pulses; wrap=0.
- rst asserted mid-operation aborts immediately to the reset values, regardless of clk.

Test Plan:
- Reset/COUNT: PRE_W=4, speed=0, mode=0, en=1, release rst -> led=8'hAA. Tick every 16 cycles; led=8'hAB, then 8'hAC.
- COUNT wrap: preload by counting to 8'hFF with PRE_W=4, speed=3 (T=1, tick every 2 cycles) -> next step led=8'h00 with wrap=1 for exactly 1 cycle, same edge as tick.
- ROTATE: mode 0->1 -> led=8'h01, prescaler cleared. Steps give 02,04,...,80, then 01 with wrap=1.
- BOUNCE: mode=2 -> led walks 01..80 then 40..01. wrap=1 only on arrival at 01. Period is 14 steps.
- Speed/en: speed 0->3 while prescaler=12 (PRE_W=4) -> step on the next cycle. en=0 for 20 cycles -> led frozen, no tick. Resuming continues from the held prescaler.
- Async reset mid-BOUNCE: assert rst between clk edges at led=8'h10 -> led=8'hAA immediately. After release with mode=2, the first cycle loads the seed 8'h01.
